// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared helpers and defaults for the zion basic circuit library pipeline blocks.
package zion_basic_circuit_lib_pkg;

    localparam int unsigned HS_PIPE_WIDTH_DEF = 32;
    localparam int unsigned HS_PIPE_DEPTH_DEF = 3;

    // Width needed to count 0..depth valid stages.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_hs_stage.sv
// One valid+data pipeline stage; data only captures on a valid load so bubbles keep old data.
module zion_basic_circuit_lib_hs_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inVld,
    input  logic [WIDTH-1:0] inDat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= inVld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat <= INI_DATA;
        end else if (load && inVld) begin
            dat <= inDat;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_hs_pipe.sv
// Multi-stage valid/ready register pipeline with bubble collapsing, synchronous flush
// and a registered occupancy count.
module zion_basic_circuit_lib_hs_pipe
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int unsigned      WIDTH    = HS_PIPE_WIDTH_DEF,
    parameter int unsigned      DEPTH    = HS_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1),
    parameter int unsigned      CNT_W    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    input  logic             iFlush,
    output logic [CNT_W-1:0] oCnt
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH:0]   mv;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] in_vld;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] cnt_q;

    // Advance chain: a stage may load if it is empty or its successor moves.
    always_comb begin
        mv        = '0;
        mv[DEPTH] = iRdy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            mv[k] = !vld[k] || mv[k+1];
        end
    end

    // Flush loads a bubble into every stage, which clears vld but leaves data intact.
    always_comb begin
        ld     = '0;
        in_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ld[k] = mv[k] || iFlush;
            if (k == 0) begin
                in_vld[k] = iVld && !iFlush;
            end else begin
                in_vld[k] = vld[k-1] && !iFlush;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (k == 0) begin : g_head
            assign stage_in = iDat;
        end else begin : g_body
            assign stage_in = dat[k-1];
        end

        zion_basic_circuit_lib_hs_stage #(
            .WIDTH    (WIDTH),
            .INI_DATA (INI_DATA)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (ld[k]),
            .inVld (in_vld[k]),
            .inDat (stage_in),
            .vld   (vld[k]),
            .dat   (dat[k])
        );
    end

    assign oRdy     = mv[0] && !iFlush;
    assign oVld     = vld[DEPTH-1] && !iFlush;
    assign oDat     = dat[DEPTH-1];
    assign in_xfer  = iVld && oRdy;
    assign out_xfer = oVld && iRdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (iFlush) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_hs_pipe.sv
// Directed self-checking bench for the handshake pipeline (WIDTH=32, DEPTH=3).
module tb_zion_basic_circuit_lib_hs_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 2;
    localparam logic [WIDTH-1:0] INI = 32'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;
    logic             iFlush;
    logic [CNT_W-1:0] oCnt;

    int checks   = 0;
    int failures = 0;

    zion_basic_circuit_lib_hs_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INI_DATA (INI)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iVld   (iVld),
        .oRdy   (oRdy),
        .iDat   (iDat),
        .oVld   (oVld),
        .iRdy   (iRdy),
        .oDat   (oDat),
        .iFlush (iFlush),
        .oCnt   (oCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance past one rising edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        iVld = 1'b1;
        iDat = d;
        #1;
        chk("push_rdy", 32'(oRdy), 32'd1);
        step();
        iVld = 1'b0;
        iDat = 'x;
    endtask

    initial begin
        rst = 1'b1; iVld = 1'b0; iRdy = 1'b1; iFlush = 1'b0; iDat = '0;
        #3;
        chk("rst_vld", 32'(oVld), 32'd0);
        chk("rst_dat", oDat, INI);
        chk("rst_cnt", 32'(oCnt), 32'd0);
        chk("rst_rdy", 32'(oRdy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1. latency
        push(32'hA5A5_0001);
        chk("lat_cnt_n", 32'(oCnt), 32'd1);
        chk("lat_vld_n", 32'(oVld), 32'd0);
        step();
        chk("lat_vld_n1", 32'(oVld), 32'd0);
        step();
        chk("lat_vld_n2", 32'(oVld), 32'd1);
        chk("lat_dat_n2", oDat, 32'hA5A5_0001);
        chk("lat_cnt_n2", 32'(oCnt), 32'd1);
        step();
        chk("lat_drain", 32'(oCnt), 32'd0);

        // 2. streaming 1..10 with iRdy=1
        for (int c = 1; c <= 12; c++) begin
            iVld = (c <= 10);
            iDat = (c <= 10) ? 32'(c) : 'x;
            #1;
            chk("strm_rdy", 32'(oRdy), 32'd1);
            step();
            if (c >= 3) begin
                chk("strm_vld", 32'(oVld), 32'd1);
                chk("strm_dat", oDat, 32'(c - 2));
            end
        end
        iVld = 1'b0;
        step();
        chk("strm_empty", 32'(oCnt), 32'd0);

        // 3. backpressure
        iRdy = 1'b0;
        push(32'd5); push(32'd6); push(32'd7);
        iVld = 1'b1; iDat = 32'd8; #1;
        chk("bp_cnt", 32'(oCnt), 32'd3);
        chk("bp_rdy", 32'(oRdy), 32'd0);
        chk("bp_dat", oDat, 32'd5);
        step();
        chk("bp_cnt_hold", 32'(oCnt), 32'd3);
        iVld = 1'b0; iRdy = 1'b1; #1;
        chk("bp_rdy_release", 32'(oRdy), 32'd1);
        for (int j = 0; j < 3; j++) begin
            chk("bp_out_vld", 32'(oVld), 32'd1);
            chk("bp_out_dat", oDat, 32'(5 + j));
            step();
        end
        chk("bp_no8_vld", 32'(oVld), 32'd0);
        chk("bp_no8_cnt", 32'(oCnt), 32'd0);

        // 4. bubble collapse
        iRdy = 1'b0;
        push(32'd1);
        step();
        push(32'd2);
        chk("bub_cnt", 32'(oCnt), 32'd2);
        chk("bub_dat", oDat, 32'd1);
        step();
        chk("bub_cnt_hold", 32'(oCnt), 32'd2);
        iRdy = 1'b1; #1;
        chk("bub_out1_vld", 32'(oVld), 32'd1);
        chk("bub_out1", oDat, 32'd1);
        step();
        chk("bub_out2_vld", 32'(oVld), 32'd1);
        chk("bub_out2", oDat, 32'd2);
        step();
        chk("bub_empty", 32'(oCnt), 32'd0);

        // 5. flush
        iRdy = 1'b0;
        push(32'hB0); push(32'hB1); push(32'hB2);
        chk("fl_full", 32'(oCnt), 32'd3);
        iFlush = 1'b1; iVld = 1'b1; iDat = 32'hCC; #1;
        chk("fl_vld", 32'(oVld), 32'd0);
        chk("fl_rdy", 32'(oRdy), 32'd0);
        step();
        iFlush = 1'b0; iVld = 1'b0; iDat = 'x; #1;
        chk("fl_cnt", 32'(oCnt), 32'd0);
        chk("fl_vld_after", 32'(oVld), 32'd0);
        chk("fl_dat_kept", oDat, 32'hB0);
        iRdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("fl_no_cc_vld", 32'(oVld), 32'd0);
        end
        chk("fl_no_cc_dat", oDat, 32'hB0);

        // 6. async reset mid-stream
        iRdy = 1'b0;
        push(32'h11); push(32'h22);
        chk("ar_cnt_pre", 32'(oCnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", 32'(oVld), 32'd0);
        chk("ar_cnt", 32'(oCnt), 32'd0);
        chk("ar_dat", oDat, INI);
        @(posedge clk); #1;
        rst = 1'b0; iRdy = 1'b1;
        push(32'h33);
        step();
        step();
        chk("ar_resume_vld", 32'(oVld), 32'd1);
        chk("ar_resume_dat", oDat, 32'h33);
        chk("ar_resume_cnt", 32'(oCnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
